riscv_run_monitor: RTL and testbench

- Synthesizable run-control and end-of-test monitor for riscv_virtual_device simulation and FPGA bring-up.
- Samples the core's debug PC and halt flag, plus a memory-write snoop bus. Decides when a run has ended and why: halt, tohost pass/fail write, PC stall, or cycle timeout.
- Also counts hits on a parametrised number of PC watchpoints.
- Benches and on-chip debug logic wait on done/cause instead of a fixed cycle count.

---
 rtl/riscv_run_monitor.sv | 151 +++++++++++++++
 tb/tb_riscv_run_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_monitor.sv
// Run-control / end-of-test monitor: decides when a core run ends and why,
// and counts hits on a set of PC watchpoints while running.
module riscv_run_monitor #(
    parameter int          XLEN        = 32,
    parameter int          NUM_WATCH   = 2,
    parameter int          CNT_W       = 32,
    parameter int          MAX_CYCLES  = 10000,
    parameter int          STALL_LIMIT = 64,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [XLEN-1:0]         pc,
    input  logic                    halted,
    input  logic                    wr_valid,
    input  logic [XLEN-1:0]         wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic [NUM_WATCH-1:0]    watch_en,
    input  logic [NUM_WATCH*XLEN-1:0] watch_pc,
    output logic                    running,
    output logic                    done,
    output logic                    pass,
    output logic [2:0]              cause,
    output logic [XLEN-1:0]         exit_code,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [NUM_WATCH-1:0]    watch_hit,
    output logic [NUM_WATCH*16-1:0] watch_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_HALT    = 3'd1;
    localparam logic [2:0] C_PASS    = 3'd2;
    localparam logic [2:0] C_FAIL    = 3'd3;
    localparam logic [2:0] C_STALL   = 3'd4;
    localparam logic [2:0] C_TIMEOUT = 3'd5;

    localparam logic [31:0]      STALL_M1 = 32'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cycle_q, cycle_d;
    logic [2:0]              cause_q, cause_d;
    logic                    pass_q, pass_d;
    logic [XLEN-1:0]         exit_q, exit_d;
    logic [XLEN-1:0]         prev_pc_q, prev_pc_d;
    logic [31:0]             stall_q, stall_d;
    logic [NUM_WATCH-1:0]    hit_q, hit_d;
    logic [NUM_WATCH*16-1:0] wcnt_q, wcnt_d;

    logic tohost_ev, stall_ev, tmo_ev, same_pc;

    assign same_pc   = (pc == prev_pc_q);
    assign tohost_ev = wr_valid && (wr_addr == TOHOST_ADDR) && (wr_data != '0);
    assign stall_ev  = (STALL_LIMIT != 0) && same_pc && (stall_q == STALL_M1);
    assign tmo_ev    = (MAX_CYCLES != 0) && (cycle_q == TMO_M1);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        cause_d   = cause_q;
        pass_d    = pass_q;
        exit_d    = exit_q;
        prev_pc_d = prev_pc_q;
        stall_d   = stall_q;
        hit_d     = hit_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cycle_d   = '0;
                    cause_d   = C_NONE;
                    pass_d    = 1'b0;
                    exit_d    = '0;
                    hit_d     = '0;
                    wcnt_d    = '0;
                    stall_d   = '0;
                    prev_pc_d = pc;
                end
            end
            S_RUN: begin
                cycle_d   = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
                prev_pc_d = pc;
                stall_d   = same_pc ? stall_q + 32'd1 : 32'd0;
                for (int i = 0; i < NUM_WATCH; i++) begin
                    if (watch_en[i] && pc == watch_pc[i*XLEN +: XLEN]) begin
                        hit_d[i] = 1'b1;
                        if (wcnt_q[i*16 +: 16] != 16'hFFFF)
                            wcnt_d[i*16 +: 16] = wcnt_q[i*16 +: 16] + 16'd1;
                    end
                end
                // Event priority: tohost > halt > stall > timeout
                if (tohost_ev) begin
                    state_d = S_DONE;
                    pass_d  = (wr_data == XLEN'(1));
                    cause_d = (wr_data == XLEN'(1)) ? C_PASS : C_FAIL;
                    exit_d  = wr_data >> 1;
                end else if (halted) begin
                    state_d = S_DONE;
                    cause_d = C_HALT;
                end else if (stall_ev) begin
                    state_d = S_DONE;
                    cause_d = C_STALL;
                end else if (tmo_ev) begin
                    state_d = S_DONE;
                    cause_d = C_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            cause_q   <= C_NONE;
            pass_q    <= 1'b0;
            exit_q    <= '0;
            prev_pc_q <= '0;
            stall_q   <= '0;
            hit_q     <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            cause_q   <= cause_d;
            pass_q    <= pass_d;
            exit_q    <= exit_d;
            prev_pc_q <= prev_pc_d;
            stall_q   <= stall_d;
            hit_q     <= hit_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign running     = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign cause       = cause_q;
    assign exit_code   = exit_q;
    assign cycle_count = cycle_q;
    assign watch_hit   = hit_q;
    assign watch_cnt   = wcnt_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Scoreboard bench for riscv_run_monitor: driver pushes expected end-of-run
// results, a monitor pops and compares each time done rises.
module tb_riscv_run_monitor;

    logic        clk = 1'b0;
    logic        rst, start, halted, wr_valid;
    logic [31:0] pc, wr_addr, wr_data;
    logic [1:0]  watch_en;
    logic [63:0] watch_pc;
    logic        running, done, pass;
    logic [2:0]  cause;
    logic [31:0] exit_code, cycle_count;
    logic [1:0]  watch_hit;
    logic [31:0] watch_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  cause;
        logic        pass;
        logic [31:0] exit_code;
        logic [31:0] count;
        logic [1:0]  hit;
        logic [31:0] wcnt;
    } exp_t;

    exp_t exp_q[$];

    riscv_run_monitor #(
        .XLEN(32), .NUM_WATCH(2), .CNT_W(32),
        .MAX_CYCLES(20), .STALL_LIMIT(4),
        .TOHOST_ADDR(32'h0000_1000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .halted(halted),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .watch_en(watch_en), .watch_pc(watch_pc),
        .running(running), .done(done), .pass(pass), .cause(cause),
        .exit_code(exit_code), .cycle_count(cycle_count),
        .watch_hit(watch_hit), .watch_cnt(watch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic arm(input logic [31:0] pc0);
        start = 1'b1;
        pc = pc0;
        step();
        start = 1'b0;
    endtask

    task automatic sample(input logic [31:0] p, input logic h,
                          input logic wv, input logic [31:0] wa,
                          input logic [31:0] wd);
        pc = p; halted = h; wr_valid = wv; wr_addr = wa; wr_data = wd;
        step();
        halted = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] c, input logic p,
                        input logic [31:0] e, input logic [31:0] n,
                        input logic [1:0] h, input logic [31:0] w);
        exp_t x;
        x.cause = c; x.pass = p; x.exit_code = e;
        x.count = n; x.hit = h; x.wcnt = w;
        exp_q.push_back(x);
    endtask

    // Monitor: one comparison set per rising done
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got cause %0d expected none",
                         cause);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("cause", cause, x.cause);
                chk("pass", pass, x.pass);
                chk("exit_code", exit_code, x.exit_code);
                chk("cycle_count", cycle_count, x.count);
                chk("watch_hit", watch_hit, x.hit);
                chk("watch_cnt", watch_cnt, x.wcnt);
                chk("running_in_done", running, 1'b0);
            end
        end
        done_d = done;
    end

    initial begin
        rst = 1'b1; start = 1'b0; pc = '0; halted = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        watch_en = 2'b00; watch_pc = {32'h10, 32'h10};
        step(); step();
        rst = 1'b0;
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cause", cause, 0);
        chk("rst_count", cycle_count, 0);

        // tohost write while idle has no effect
        sample(32'h4, 1'b0, 1'b1, 32'h1000, 32'h1);
        chk("idle_tohost_done", done, 0);
        chk("idle_tohost_cause", cause, 0);

        // Halt on sample 7
        push(3'd1, 1'b0, 32'h0, 32'd7, 2'b00, 32'h0);
        arm(32'h100);
        for (int s = 1; s <= 7; s++) begin
            sample(32'h100 + 32'(4 * s), s == 7, 1'b0, 32'h0, 32'h0);
            if (s == 6) chk("halt_not_yet", done, 0);
        end
        chk("halt_latency", done, 1);

        // tohost pass on sample 3; zero write and wrong address ignored
        push(3'd2, 1'b1, 32'h0, 32'd3, 2'b00, 32'h0);
        arm(32'h200);
        sample(32'h204, 1'b0, 1'b1, 32'h1000, 32'h0);
        sample(32'h208, 1'b0, 1'b1, 32'h1004, 32'h1);
        chk("tohost_zero_ignored", running, 1);
        sample(32'h20C, 1'b0, 1'b1, 32'h1000, 32'h1);
        chk("pass_latency", done, 1);

        // Re-arm from DONE, tohost fail 0x2B on sample 2
        push(3'd3, 1'b0, 32'h15, 32'd2, 2'b00, 32'h0);
        arm(32'h300);
        sample(32'h304, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h308, 1'b0, 1'b1, 32'h1000, 32'h2B);
        chk("fail_latency", done, 1);
        // DONE ignores tohost and halt
        sample(32'h30C, 1'b1, 1'b1, 32'h1000, 32'h1);
        chk("done_hold_cause", cause, 3);
        chk("done_hold_pass", pass, 0);

        // Stall: pc held from arming, STALL_LIMIT=4
        push(3'd4, 1'b0, 32'h0, 32'd4, 2'b00, 32'h0);
        arm(32'h80);
        for (int s = 1; s <= 4; s++) begin
            sample(32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
            if (s == 3) chk("stall_not_yet", running, 1);
        end
        chk("stall_latency", done, 1);
        sample(32'h84, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h88, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("done_hold_count", cycle_count, 4);

        // Timeout: MAX_CYCLES=20
        push(3'd5, 1'b0, 32'h0, 32'd20, 2'b00, 32'h0);
        arm(32'h400);
        for (int s = 1; s <= 20; s++) begin
            sample(32'h400 + 32'(4 * s), 1'b0, 1'b0, 32'h0, 32'h0);
            if (s == 19) chk("timeout_not_yet", running, 1);
        end
        chk("timeout_latency", done, 1);

        // Halt and tohost pass together: tohost wins
        push(3'd2, 1'b1, 32'h0, 32'd2, 2'b00, 32'h0);
        arm(32'h500);
        sample(32'h504, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h508, 1'b1, 1'b1, 32'h1000, 32'h1);

        // Watchpoints: ch0 enabled, ch1 disabled, both at 0x10
        watch_en = 2'b01;
        push(3'd1, 1'b0, 32'h0, 32'd5, 2'b01, {16'd0, 16'd3});
        arm(32'h0);
        sample(32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
        sample(32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("watch_frozen_in_done", watch_cnt, {16'd0, 16'd3});
        watch_en = 2'b00;

        // Reset mid-run at sample 5, then re-arm
        arm(32'h600);
        for (int s = 1; s <= 4; s++)
            sample(32'h600 + 32'(4 * s), 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        sample(32'h614, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        chk("midrst_running", running, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", cycle_count, 0);
        chk("midrst_cause", cause, 0);
        chk("midrst_wcnt", watch_cnt, 0);
        sample(32'h618, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_idle", running, 0);
        push(3'd1, 1'b0, 32'h0, 32'd2, 2'b00, 32'h0);
        arm(32'h700);
        sample(32'h704, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rearm_count1", cycle_count, 1);
        sample(32'h708, 1'b1, 1'b0, 32'h0, 32'h0);

        step(); step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
